// File: rtl/i2s_tx_if.sv
// Sample-side bus of the i2s_tx audio back-end: the filter's sample strobe
// and FIFO status going one way, the I2S lines going out to the DAC.
// "master" is the sample source; "slave" is the i2s_tx block itself.
interface i2s_tx_if #(
  parameter int N_BITS = 24
) ();
  logic signed [N_BITS-1:0] sample_in;
  logic                     sample_valid;
  logic                     fifo_full;
  logic                     overflow;
  logic                     underrun;
  logic                     bclk;
  logic                     lrclk;
  logic                     sdata;

  modport master (
    output sample_in, sample_valid,
    input  fifo_full, overflow, underrun, bclk, lrclk, sdata
  );

  modport slave (
    input  sample_in, sample_valid,
    output fifo_full, overflow, underrun, bclk, lrclk, sdata
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: buffers mono samples in a small FIFO and serializes each one as a
// Philips I2S frame (same word in the left and right slots). The block is
// the I2S bus master and derives bclk/lrclk from ck.
// Optional feature macro I2S_TX_UNDERRUN_HOLD_EN: when defined, an underrun
// repeats the previous frame word instead of sending silence.
module i2s_tx #(
  parameter int N_BITS     = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic   ck,
  input logic   rst,
  i2s_tx_if.slave bus
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  SLOT_LEN = IDX_W'(SLOT_BITS);
  localparam logic [IDX_W-1:0]  MSB_POS  = IDX_W'(N_BITS);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [N_BITS-1:0] BIT_ONE  = N_BITS'(1);

  // registered state
  logic [DIV_W-1:0]  div_cnt_r;
  logic              bclk_r;
  logic              lrclk_r;
  logic              sdata_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic [N_BITS-1:0] frame_word_r;
  logic [N_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic              fifo_full_r;
  logic              overflow_r;
  logic              underrun_r;

  // next-state / decode
  logic              tick_s;
  logic              frame_start_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              push_s;
  logic [DIV_W-1:0]  div_next_s;
  logic [IDX_W-1:0]  bit_idx_next_s;
  logic [IDX_W-1:0]  pos_s;
  logic              lrclk_next_s;
  logic              sdata_next_s;
  logic [N_BITS-1:0] bit_mask_s;
  logic [N_BITS-1:0] frame_word_next_s;
  logic [CW-1:0]     count_next_s;

  // Divider tick, frame position, FIFO handshake and the next serial bit.
  always_comb begin
    tick_s            = (div_cnt_r == DIV_LAST);
    div_next_s        = div_cnt_r + DIV_ONE;
    bit_idx_next_s    = bit_idx_r;
    frame_word_next_s = frame_word_r;
    sdata_next_s      = 1'b0;

    if (tick_s) begin
      div_next_s = {DIV_W{1'b0}};
    end else begin
      div_next_s = div_cnt_r + DIV_ONE;
    end

    frame_start_s = tick_s && (bit_idx_r == IDX_LAST);
    fifo_empty_s  = (count_r == {CW{1'b0}});
    // A pop only happens with data present, so an empty FIFO never bypasses.
    pop_s         = frame_start_s && !fifo_empty_s;
    push_s        = bus.sample_valid && ((count_r != FULL_CNT) || pop_s);
    count_next_s  = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

    if (!tick_s) begin
      bit_idx_next_s = bit_idx_r;
    end else if (bit_idx_r == IDX_LAST) begin
      bit_idx_next_s = {IDX_W{1'b0}};
    end else begin
      bit_idx_next_s = bit_idx_r + IDX_ONE;
    end

    if (pop_s) begin
      frame_word_next_s = mem_r[rd_ptr_r];
    end else if (frame_start_s) begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      frame_word_next_s = frame_word_r;
`else
      frame_word_next_s = {N_BITS{1'b0}};
`endif
    end else begin
      frame_word_next_s = frame_word_r;
    end

    lrclk_next_s = (bit_idx_next_s >= SLOT_LEN);
    if (lrclk_next_s) begin
      pos_s = bit_idx_next_s - SLOT_LEN;
    end else begin
      pos_s = bit_idx_next_s;
    end

    // One-bit I2S delay: MSB at slot position 1, LSB at position N_BITS.
    bit_mask_s = BIT_ONE << (MSB_POS - pos_s);
    if ((pos_s != {IDX_W{1'b0}}) && (pos_s <= MSB_POS)) begin
      sdata_next_s = |(frame_word_next_s & bit_mask_s);
    end else begin
      sdata_next_s = 1'b0;
    end
  end

  // Divider, I2S line registers, frame word and FIFO bookkeeping.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      div_cnt_r    <= {DIV_W{1'b0}};
      bclk_r       <= 1'b0;
      lrclk_r      <= 1'b0;
      sdata_r      <= 1'b0;
      bit_idx_r    <= IDX_LAST;
      frame_word_r <= {N_BITS{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      fifo_full_r  <= 1'b0;
      overflow_r   <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      div_cnt_r    <= div_next_s;
      // bclk falls on the same edge that moves lrclk/sdata
      bclk_r       <= (div_next_s >= DIV_HALF);
      bit_idx_r    <= bit_idx_next_s;
      frame_word_r <= frame_word_next_s;
      if (tick_s) begin
        lrclk_r <= lrclk_next_s;
        sdata_r <= sdata_next_s;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      fifo_full_r <= (count_next_s == FULL_CNT);
      overflow_r  <= bus.sample_valid && !push_s;
      underrun_r  <= frame_start_s && fifo_empty_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge ck) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.sample_in;
    end
  end

  assign bus.bclk      = bclk_r;
  assign bus.lrclk     = lrclk_r;
  assign bus.sdata     = sdata_r;
  assign bus.fifo_full = fifo_full_r;
  assign bus.overflow  = overflow_r;
  assign bus.underrun  = underrun_r;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a queue-based reference model driven by the
// stimulus pushes per-cycle expectations; a monitor pops and compares them.
module tb_i2s_tx;
  localparam int N_BITS     = 24;
  localparam int SLOT_BITS  = 32;
  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CK   = 2 * SLOT_BITS * BCLK_DIV;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  i2s_tx_if #(.N_BITS(N_BITS)) bus ();

  i2s_tx #(
    .N_BITS(N_BITS), .SLOT_BITS(SLOT_BITS),
    .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ck(ck), .rst(rst), .bus(bus)
  );

  always #5 ck = ~ck;

  typedef struct {
    int              cyc;
    logic            ur;
    logic            ov;
    logic            full;
    logic [N_BITS-1:0] word;
  } exp_t;

  exp_t              eq[$];
  logic [N_BITS-1:0] mq[$];
  logic [N_BITS-1:0] fw;
  int                cyc;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of input (positioned at a negedge) and model its edge.
  task automatic step(input logic v, input logic [N_BITS-1:0] d);
    exp_t e;
    int   off;
    logic popped;
    bus.sample_valid = v;
    bus.sample_in    = d;
    cyc++;
    off    = cyc - BCLK_DIV;
    popped = 1'b0;
    e.ur   = 1'b0;
    e.ov   = 1'b0;
    if (off >= 0 && (off % FRAME_CK) == 0) begin
      if (mq.size() > 0) begin
        fw     = mq.pop_front();
        popped = 1'b1;
      end else begin
        e.ur = 1'b1;
`ifndef I2S_TX_UNDERRUN_HOLD_EN
        fw = '0;
`endif
      end
    end
    if (v) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(d);
      else e.ov = 1'b1;
    end
    e.cyc  = cyc;
    e.full = (mq.size() == FIFO_DEPTH);
    e.word = fw;
    eq.push_back(e);
    @(negedge ck);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, N_BITS'($urandom));
  endtask

  // Step until the next step lands on frame offset 'off'.
  task automatic idle_to(input int off);
    for (int guard = 0; guard < FRAME_CK + BCLK_DIV + 2; guard++) begin
      if ((cyc + 1 - BCLK_DIV) >= 0 && ((cyc + 1 - BCLK_DIV) % FRAME_CK) == off) break;
      step(1'b0, N_BITS'($urandom));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    #1;
    chk("rst_bclk", bus.bclk, 0);
    chk("rst_lrclk", bus.lrclk, 0);
    chk("rst_sdata", bus.sdata, 0);
    chk("rst_fifo_full", bus.fifo_full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underrun", bus.underrun, 0);
    mq.delete();
    eq.delete();
    fw  = '0;
    cyc = 0;
    repeat (2) @(negedge ck);
    rst = 1'b0;
  endtask

  // Monitor: one expectation per ck edge, plus DAC-style slot capture.
  exp_t        me;
  int          mt, mj, mp;
  logic        exp_bclk, exp_lr, exp_sd;
  logic [31:0] acc;
  initial begin
    acc = '0;
    forever begin
      @(posedge ck);
      #1;
      if (!rst && eq.size() > 0) begin
        me       = eq.pop_front();
        exp_bclk = (me.cyc % BCLK_DIV) >= (BCLK_DIV / 2);
        exp_lr   = 1'b0;
        exp_sd   = 1'b0;
        mp       = -1;
        if (me.cyc >= BCLK_DIV) begin
          mt     = me.cyc - BCLK_DIV;
          mj     = (mt / BCLK_DIV) % (2 * SLOT_BITS);
          mp     = mj % SLOT_BITS;
          exp_lr = (mj >= SLOT_BITS);
          if (mp >= 1 && mp <= N_BITS) exp_sd = me.word[N_BITS - mp];
        end
        chk("bclk", bus.bclk, exp_bclk);
        chk("lrclk", bus.lrclk, exp_lr);
        chk("sdata", bus.sdata, exp_sd);
        chk("underrun", bus.underrun, me.ur);
        chk("overflow", bus.overflow, me.ov);
        chk("fifo_full", bus.fifo_full, me.full);
        if (me.cyc >= BCLK_DIV && (me.cyc % BCLK_DIV) == (BCLK_DIV / 2)) begin
          acc = {acc[30:0], bus.sdata};
          if (mp == SLOT_BITS - 1)
            chk(exp_lr ? "right_slot" : "left_slot", acc, {1'b0, me.word, 7'b0});
        end
      end
    end
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    @(negedge ck);

    // idle after reset: silence, underrun every frame
    do_reset();
    idle(2 * FRAME_CK + 10);

    // single sample before the first tick
    do_reset();
    step(1'b1, 24'h800001);
    idle(2 * FRAME_CK + 10);

    // five back-to-back pushes from empty: fifth is dropped
    idle_to(10);
    for (int i = 0; i < 5; i++) step(1'b1, N_BITS'($urandom));
    idle(5 * FRAME_CK);

    // full FIFO with a strobe exactly on the frame-start pop
    idle_to(20);
    for (int i = 0; i < 4; i++) step(1'b1, N_BITS'($urandom));
    idle_to(0);
    step(1'b1, 24'hABCDEF);
    idle(5 * FRAME_CK + 10);

    // random bursts
    for (int r = 0; r < 12; r++) begin
      idle($urandom_range(20, 400));
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) step(1'b1, N_BITS'($urandom));
    end
    idle(4 * FRAME_CK);

    // reset mid-frame with two samples queued
    idle_to(10);
    for (int i = 0; i < 3; i++) step(1'b1, N_BITS'($urandom));
    idle_to(0);
    step(1'b0, '0);
    idle_to(40 * BCLK_DIV);
    do_reset();
    idle(2 * FRAME_CK + 10);

    // single sample then starvation (repeats under the hold option)
    idle_to(10);
    step(1'b1, 24'h123456);
    idle(4 * FRAME_CK);

    bus.sample_valid = 1'b0;
    @(posedge ck);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output back-end for the filter datapath.
- Accepts signed samples as single-cycle valid strobes (the filter's out/output_ready pair) and buffers them in a small FIFO.
- Serializes each sample as standard Philips I2S to an external DAC; the mono sample is duplicated into the left and right slots.
- Generates bclk and lrclk from the system clock; the block is the I2S bus master.

Parameters:
- N_BITS, 24, sample width; must be ≤ SLOT_BITS-1.
- SLOT_BITS, 32, bclk periods per channel slot.
- BCLK_DIV, 4, ck cycles per bclk period; even, ≥ 2.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, ≥ 2.

Ports:
- ck, input, 1, system clock; all logic on posedge.
- rst, input, 1, reset, asynchronous, active-high.
- sample_in, input, N_BITS, signed two's-complement sample.
- sample_valid, input, 1, one-cycle strobe qualifying sample_in.
- fifo_full, output, 1, FIFO holds FIFO_DEPTH entries.
- overflow, output, 1, one-cycle pulse when a strobed sample is dropped.
- underrun, output, 1, one-cycle pulse when a frame starts with the FIFO empty.
- bclk, output, 1, I2S bit clock.
- lrclk, output, 1, I2S word select; 0 = left, 1 = right.
- sdata, output, 1, I2S serial data, MSB first.

Behaviour:
- Reset values:
  - bclk=0, lrclk=0, sdata=0, fifo_full=0, overflow=0, underrun=0.
  - FIFO empty; div_cnt=0; bit_idx=2*SLOT_BITS-1; frame word=0.
- Reset mid-frame aborts the frame immediately. No partial word is replayed after release.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk is registered: 1 while div_cnt ≥ BCLK_DIV/2, else 0.
  - tick = (div_cnt == BCLK_DIV-1); the falling edge of bclk follows every tick.
- On every tick:
  - bit_idx increments, wrapping 2*SLOT_BITS-1 → 0.
  - lrclk and sdata update in the same edge as bclk falls; the DAC samples on bclk rise.
- Frame start (tick with bit_idx wrapping to 0):
  - FIFO non-empty: pop the head into the frame word.
  - FIFO empty: frame word = 0 and underrun pulses for 1 ck.
- lrclk = (bit_idx ≥ SLOT_BITS).
- sdata (I2S one-bit delay):
  - Slot position p = bit_idx mod SLOT_BITS.
  - For 1 ≤ p ≤ N_BITS: sdata = frame_word[N_BITS-p]. The MSB goes out at p=1, the LSB at p=N_BITS.
  - All other p: sdata = 0.
  - The right slot carries the same word as the left.
- FIFO:
  - Push when sample_valid and (not full, or a pop occurs in the same cycle).
  - sample_valid while full with no pop: sample dropped, overflow pulses, contents unchanged.
  - Simultaneous push and pop on an empty FIFO: the pop sees empty (underrun, no bypass) and the push is stored.
  - fifo_full is registered and reflects the post-update count.
- First frame after reset starts at the first tick (ck cycle BCLK_DIV after release).
- Frame period = 2*SLOT_BITS*BCLK_DIV ck cycles (256 at defaults).
- Sustained input rate must be ≤ 1 sample per frame, otherwise overflow fires.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_HOLD_EN.
- Defined: on underrun the frame word keeps its previous value, so the last sample repeats. The underrun pulse is still generated.
- Not defined: on underrun the frame word is 0 (silence), as specified above.

Test Plan:
- Reset, no input, defaults:
  - bclk toggles with period 4 ck.
  - lrclk is 0 for 32 bclk periods, then 1 for 32.
  - sdata constant 0.
  - underrun pulses every 256 ck, first at ck 4 after release.
- Push 24'h800001 before the first tick:
  - Left slot serializes 1, then 22 zeros, then 1 at p=1..24; p=0 and p=25..31 are 0.
  - Right slot is identical.
  - The next frame is zero with an underrun pulse.
- Push 5 samples back-to-back from empty:
  - fifo_full rises after the 4th push.
  - The 5th push is dropped with an overflow pulse.
  - The four stored samples emit in order over the next 4 frames.
- FIFO full with sample_valid exactly on a frame-start pop:
  - No overflow.
  - Count stays 4.
  - The new sample appears 4 frames later.
- Assert rst mid-frame (bit_idx ≈ 40) with 2 samples queued:
  - All outputs go to reset values asynchronously.
  - After release the FIFO is empty and the first frame underruns.
- With I2S_TX_UNDERRUN_HOLD_EN: push 24'h123456 once.
  - Every subsequent frame repeats 24'h123456 in both slots, with an underrun pulse per frame.
